// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS load/store unit: opcodes, state
// encoding and opcode classification helpers.
package mips_cpu_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lsu_state_t;

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  // Halfword accesses need an even address, word accesses a word-aligned
  // one; byte and unaligned-word (lwl/lwr) accesses never fault.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return (off != 2'b00);
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_lsu_if.sv
// Request/response and Avalon-MM data bus signals of the load/store unit.
// master = the LSU itself, slave = the core/bus side driving it.
interface mips_cpu_lsu_if;
  logic        req_valid;
  logic [5:0]  req_opcode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic [1:0]  addr_offset;
  logic        misaligned;
  logic        bus_error;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    input  req_valid, req_opcode, req_addr, req_wdata,
    input  avm_waitrequest, avm_readdata,
    output busy, done, load_data, addr_offset, misaligned, bus_error,
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );

  modport slave (
    output req_valid, req_opcode, req_addr, req_wdata,
    output avm_waitrequest, avm_readdata,
    input  busy, done, load_data, addr_offset, misaligned, bus_error,
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/mips_cpu_lsu_store_align.sv
// Byte-lane steering for stores: replicates the store data across lanes
// and selects the byteenables. Loads always enable all four lanes.
module mips_cpu_lsu_store_align
  import mips_cpu_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  byteenable_o,
  output logic [31:0] writedata_o
);

  // Lane selection and data replication per store width
  always_comb begin
    byteenable_o = 4'b1111;
    writedata_o  = wdata_i;
    case (opcode_i)
      OP_SB: begin
        byteenable_o = 4'b0001 << addr_lo_i;
        writedata_o  = {4{wdata_i[7:0]}};
      end
      OP_SH: begin
        byteenable_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        writedata_o  = {2{wdata_i[15:0]}};
      end
      default: begin
        byteenable_o = 4'b1111;
        writedata_o  = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_lsu.sv
// Load/store unit: takes one request from the datapath, issues a single
// word-aligned Avalon-MM access and returns the raw word plus byte offset.
module mips_cpu_lsu
  import mips_cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd256
) (
  input  logic         clk,
  input  logic         reset_n,
  mips_cpu_lsu_if.master bus
);

  localparam logic [31:0] TMO_LIMIT = TIMEOUT_CYCLES;
  localparam logic        TMO_EN    = (TIMEOUT_CYCLES != 32'd0);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic [1:0]  offset_q, offset_d;
  logic        misaligned_q, misaligned_d;
  logic        bus_error_q, bus_error_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  logic [3:0]  align_be_s;
  logic [31:0] align_wdata_s;

  mips_cpu_lsu_store_align u_store_align (
    .opcode_i     (bus.req_opcode),
    .addr_lo_i    (bus.req_addr[1:0]),
    .wdata_i      (bus.req_wdata),
    .byteenable_o (align_be_s),
    .writedata_o  (align_wdata_s)
  );

  // State register and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= 32'd0;
      be_q         <= 4'd0;
      wdata_q      <= 32'd0;
      load_data_q  <= 32'd0;
      offset_q     <= 2'd0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      tmo_cnt_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      load_data_q  <= load_data_d;
      offset_q     <= offset_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  // Next-state: accept/fault in IDLE, wait out waitrequest, pulse DONE
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    load_data_d  = load_data_q;
    offset_d     = offset_q;
    misaligned_d = 1'b0;
    bus_error_d  = 1'b0;
    tmo_cnt_d    = tmo_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && (is_load(bus.req_opcode) || is_store(bus.req_opcode))) begin
          offset_d = bus.req_addr[1:0];
          if (is_misaligned(bus.req_opcode, bus.req_addr[1:0])) begin
            misaligned_d = 1'b1;
          end else begin
            addr_d    = {bus.req_addr[31:2], 2'b00};
            be_d      = align_be_s;
            wdata_d   = align_wdata_s;
            tmo_cnt_d = 32'd0;
            state_d   = is_load(bus.req_opcode) ? READ : WRITE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ, WRITE: begin
        if (!bus.avm_waitrequest) begin
          if (state_q == READ) begin
            load_data_d = bus.avm_readdata;
          end else begin
            load_data_d = load_data_q;
          end
          state_d = DONE;
        end else if (TMO_EN && ((tmo_cnt_q + 32'd1) == TMO_LIMIT)) begin
          // Slave never answered: abort, keep previous load_data
          tmo_cnt_d   = tmo_cnt_q + 32'd1;
          bus_error_d = 1'b1;
          state_d     = DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy           = (state_q != IDLE);
  assign bus.done           = (state_q == DONE);
  assign bus.avm_read       = (state_q == READ);
  assign bus.avm_write      = (state_q == WRITE);
  assign bus.avm_address    = addr_q;
  assign bus.avm_byteenable = be_q;
  assign bus.avm_writedata  = wdata_q;
  assign bus.load_data      = load_data_q;
  assign bus.addr_offset    = offset_q;
  assign bus.misaligned     = misaligned_q;
  assign bus.bus_error      = bus_error_q;

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Self-checking bench for mips_cpu_lsu: directed scenarios plus randomized
// accesses compared against a lane-level reference model.
module tb_mips_cpu_lsu;
  import mips_cpu_pkg::*;

  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mips_cpu_lsu_if bus ();

  mips_cpu_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_load = 32'd0;

  // Reference: one memory access described by opcode width and lane range.
  task automatic do_access(input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input int nwait,
                           input logic [31:0] rd, input bit tmo);
    bit ld, st, flt;
    int sz, off, base, ncyc;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    ld  = op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR};
    st  = op inside {OP_SB, OP_SH, OP_SW};
    sz  = (op inside {OP_LH, OP_LHU, OP_SH}) ? 2 : ((op inside {OP_LW, OP_SW}) ? 4 : 1);
    off = int'(addr[1:0]);
    flt = (op inside {OP_LH, OP_LHU, OP_SH, OP_LW, OP_SW}) && ((off % sz) != 0);
    base = off - (off % sz);
    for (int l = 0; l < 4; l++) begin
      ebe[l] = ld ? 1'b1 : ((l >= base) && (l < base + sz));
      ewd[8*l +: 8] = wd[8*(l % sz) +: 8];
    end
    ncyc = tmo ? int'(TMO) : nwait + 1;

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_opcode = op; bus.req_addr = addr; bus.req_wdata = wd;
    bus.avm_waitrequest = (nwait > 0) || tmo; bus.avm_readdata = $urandom;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (flt) begin
      n_cmp++; if (bus.misaligned !== 1'b1) begin n_bad++; $display("FAIL misaligned_pulse op=%b addr=%h got %b want 1", op, addr, bus.misaligned); end
      n_cmp++; if ({bus.busy, bus.avm_read, bus.avm_write, bus.done} !== 4'b0000) begin n_bad++; $display("FAIL fault_quiet got busy/rd/wr/done=%b want 0000", {bus.busy, bus.avm_read, bus.avm_write, bus.done}); end
      n_cmp++; if (bus.addr_offset !== addr[1:0]) begin n_bad++; $display("FAIL fault_offset got %0d want %0d", bus.addr_offset, addr[1:0]); end
      @(negedge clk);
      n_cmp++; if ({bus.misaligned, bus.busy, bus.avm_read, bus.avm_write} !== 4'b0000) begin n_bad++; $display("FAIL fault_after got mis/busy/rd/wr=%b want 0000", {bus.misaligned, bus.busy, bus.avm_read, bus.avm_write}); end
    end else begin
      for (int c = 0; c < ncyc; c++) begin
        n_cmp++; if ({bus.busy, bus.done, bus.avm_read, bus.avm_write} !== {1'b1, 1'b0, ld, st}) begin n_bad++; $display("FAIL strobe c=%0d op=%b got busy/done/rd/wr=%b want %b", c, op, {bus.busy, bus.done, bus.avm_read, bus.avm_write}, {1'b1, 1'b0, ld, st}); end
        n_cmp++; if (bus.avm_address !== {addr[31:2], 2'b00}) begin n_bad++; $display("FAIL address c=%0d got %h want %h", c, bus.avm_address, {addr[31:2], 2'b00}); end
        n_cmp++; if (bus.avm_byteenable !== ebe) begin n_bad++; $display("FAIL byteenable c=%0d op=%b addr=%h got %b want %b", c, op, addr, bus.avm_byteenable, ebe); end
        if (st) begin
          n_cmp++; if (bus.avm_writedata !== ewd) begin n_bad++; $display("FAIL writedata c=%0d op=%b got %h want %h", c, op, bus.avm_writedata, ewd); end
        end
        bus.avm_waitrequest = tmo || (c < nwait);
        bus.avm_readdata = bus.avm_waitrequest ? $urandom : rd;
        @(negedge clk);
      end
      if (ld && !tmo) model_load = rd;
      n_cmp++; if ({bus.done, bus.busy, bus.avm_read, bus.avm_write} !== 4'b1100) begin n_bad++; $display("FAIL done_cycle got done/busy/rd/wr=%b want 1100", {bus.done, bus.busy, bus.avm_read, bus.avm_write}); end
      n_cmp++; if (bus.bus_error !== tmo) begin n_bad++; $display("FAIL bus_error got %b want %b", bus.bus_error, tmo); end
      n_cmp++; if (bus.load_data !== model_load) begin n_bad++; $display("FAIL load_data got %h want %h", bus.load_data, model_load); end
      n_cmp++; if (bus.addr_offset !== addr[1:0]) begin n_bad++; $display("FAIL addr_offset got %0d want %0d", bus.addr_offset, addr[1:0]); end
      bus.avm_waitrequest = 1'b0;
      @(negedge clk);
      n_cmp++; if ({bus.busy, bus.done, bus.bus_error} !== 3'b000) begin n_bad++; $display("FAIL return_idle got busy/done/err=%b want 000", {bus.busy, bus.done, bus.bus_error}); end
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if ({bus.busy, bus.done, bus.misaligned, bus.bus_error, bus.avm_read, bus.avm_write} !== 6'b0) begin n_bad++; $display("FAIL reset_flags got %b want 000000", {bus.busy, bus.done, bus.misaligned, bus.bus_error, bus.avm_read, bus.avm_write}); end
    n_cmp++; if ({bus.load_data, bus.avm_address, bus.avm_writedata, bus.addr_offset, bus.avm_byteenable} !== 102'd0) begin n_bad++; $display("FAIL reset_data got ld=%h a=%h wd=%h off=%0d be=%b want zeros", bus.load_data, bus.avm_address, bus.avm_writedata, bus.addr_offset, bus.avm_byteenable); end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    do_access(OP_LW, 32'h0000_1004, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    do_access(OP_SB, 32'h0000_2003, 32'h0000_00A5, 3, 32'h0, 1'b0);
    do_access(OP_SH, 32'h0000_3001, 32'h1234_5678, 0, 32'h0, 1'b0);
    do_access(OP_LH, 32'h0000_3002, 32'h0, 1, 32'h0BAD_F00D, 1'b0);
  endtask

  task automatic test_timeout();
    do_access(OP_LWR, 32'h0000_4003, 32'h0, 0, 32'h1111_2222, 1'b1);
    do_access(OP_SW, 32'h0000_5000, 32'hCAFE_0001, 0, 32'h0, 1'b1);
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_opcode = OP_LW; bus.req_addr = 32'h0000_6000;
    bus.avm_waitrequest = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.avm_read !== 1'b1) begin n_bad++; $display("FAIL pre_reset_read got %b want 1", bus.avm_read); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({bus.avm_read, bus.busy} !== 2'b00) begin n_bad++; $display("FAIL reset_drop got rd/busy=%b want 00", {bus.avm_read, bus.busy}); end
    model_load = 32'd0;
    @(negedge clk);
    n_cmp++; if ({bus.done, bus.busy, bus.load_data} !== 34'd0) begin n_bad++; $display("FAIL reset_no_done got done=%b busy=%b ld=%h want 0", bus.done, bus.busy, bus.load_data); end
    reset_n = 1'b1;
    bus.avm_waitrequest = 1'b0;
    do_access(OP_LBU, 32'h0000_7001, 32'h0, 0, 32'h5566_7788, 1'b0);
  endtask

  task automatic test_ignored_opcode();
    logic [5:0] ops [3];
    ops[0] = 6'b000000; ops[1] = 6'b101010; ops[2] = 6'b100111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_opcode = ops[k]; bus.req_addr = 32'h0000_8001;
      @(negedge clk);
      n_cmp++; if ({bus.busy, bus.done, bus.misaligned, bus.bus_error, bus.avm_read, bus.avm_write} !== 6'b0) begin n_bad++; $display("FAIL ignored_op op=%b got %b want 000000", ops[k], {bus.busy, bus.done, bus.misaligned, bus.bus_error, bus.avm_read, bus.avm_write}); end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_wr;
    exp_wr = 4'b1001;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_opcode = OP_SW; bus.req_addr = 32'h0000_9000;
    bus.req_wdata = 32'hAAAA_0001; bus.avm_waitrequest = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin bus.req_addr = 32'h0000_9010; bus.req_wdata = 32'hBBBB_0002; end
      n_cmp++; if (bus.avm_write !== exp_wr[c]) begin n_bad++; $display("FAIL b2b_write c=%0d got %b want %b", c, bus.avm_write, exp_wr[c]); end
      n_cmp++; if (bus.done !== (c == 1)) begin n_bad++; $display("FAIL b2b_done c=%0d got %b want %b", c, bus.done, (c == 1)); end
    end
    n_cmp++; if ({bus.avm_address, bus.avm_writedata} !== {32'h0000_9010, 32'hBBBB_0002}) begin n_bad++; $display("FAIL b2b_second got a=%h wd=%h want 00009010 bbbb0002", bus.avm_address, bus.avm_writedata); end
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL b2b_done2 got %b want 1", bus.done); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [5:0] legal [10];
    legal[0] = OP_LB; legal[1] = OP_LH; legal[2] = OP_LWL; legal[3] = OP_LW; legal[4] = OP_LBU;
    legal[5] = OP_LHU; legal[6] = OP_LWR; legal[7] = OP_SB; legal[8] = OP_SH; legal[9] = OP_SW;
    for (int n = 0; n < 60; n++) begin
      do_access(legal[$urandom_range(0, 9)], $urandom, $urandom, int'($urandom_range(0, 2)), $urandom, 1'b0);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_opcode = 6'd0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    bus.avm_waitrequest = 1'b0; bus.avm_readdata = 32'd0;
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid_access();
    test_ignored_opcode();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_cpu_lsu.md
Name: mips_cpu_lsu

Overview:
Load/store unit between the datapath and the Avalon-MM data bus; directly upstream of the register file's write port for loads.
- Accepts one memory request (opcode, effective address, store data) and issues a word-aligned Avalon read or write with byteenables.
- Waits out waitrequest, then returns the raw aligned 32-bit word plus the address byte offset. The register file performs byte/half/lwl/lwr extraction from that word.
- Stalls the core via busy while an access is outstanding.

Parameters:
TIMEOUT_CYCLES, 256, max consecutive waitrequest cycles before abort with bus_error; 0 disables timeout.

Ports:
clk  in  1  system clock, all state updates on posedge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present; sampled only in IDLE
req_opcode  in  6  MIPS primary opcode of the instruction
req_addr  in  32  effective byte address
req_wdata  in  32  store source register (value in low bits for sb/sh)
busy  out  1  high whenever state != IDLE; core stalls
done  out  1  one-cycle pulse: access complete (or aborted)
load_data  out  32  raw word from bus, held until next captured read
addr_offset  out  2  req_addr[1:0] of last accepted request, held
misaligned  out  1  one-cycle pulse: alignment fault, no bus access
bus_error  out  1  one-cycle pulse with done on timeout abort
avm_address  out  32  {req_addr[31:2],2'b00}
avm_read  out  1  Avalon read strobe
avm_write  out  1  Avalon write strobe
avm_writedata  out  32  lane-replicated store data
avm_byteenable  out  4  active byte lanes
avm_waitrequest  in  1  slave stall
avm_readdata  in  32  read data, valid in the cycle waitrequest is low

Behaviour:
- Reset (async, immediate): state IDLE. Outputs busy, done, misaligned, bus_error, avm_read, avm_write = 0. load_data, avm_address, avm_writedata = 0. addr_offset = 0. avm_byteenable = 0. Timeout counter = 0. Reset mid-access drops strobes immediately; no done is generated.
- Load opcodes: lb 100000, lh 100001, lwl 100010, lw 100011, lbu 100100, lhu 100101, lwr 100110. Store opcodes: sb 101000, sh 101001, sw 101011.
- Any other opcode with req_valid = 1: ignored, no pulse, stay IDLE.
- Alignment faults:
  - lh/lhu/sh with addr[0] = 1.
  - lw/sw with addr[1:0] != 0.
  - lb/lbu/sb/lwl/lwr never fault.
  - On a fault: misaligned pulses for exactly the cycle after the sampling edge; state stays IDLE; no strobe; addr_offset is updated.
- States:
  - IDLE: on a legal request, register the address, byteenable and writedata; then go to READ (loads, avm_read = 1) or WRITE (stores, avm_write = 1). Strobe is high from the cycle after the sampling edge.
  - READ/WRITE: address, strobe, writedata and byteenable are held stable while avm_waitrequest = 1. At the first edge with waitrequest = 0: drop the strobe; on READ capture avm_readdata into load_data; go to DONE.
  - DONE: done = 1 for one cycle, busy still 1; next edge returns to IDLE.
- Latency: request sampled at edge E0, zero wait states:
  - strobe high in cycle E0–E1;
  - done high in cycle E1–E2;
  - new request accepted at E3.
  - Each wait state adds one cycle.
- Load byteenable = 4'b1111 for all loads.
- Stores:
  - sb: byteenable = 1 << addr[1:0]; writedata = {4{wdata[7:0]}}.
  - sh: byteenable = addr[1] ? 1100 : 0011; writedata = {2{wdata[15:0]}}.
  - sw: byteenable = 1111; writedata = wdata.
- Timeout: counter increments each READ/WRITE cycle with waitrequest = 1. When the counter equals TIMEOUT_CYCLES (non-zero), drop the strobe and go to DONE with bus_error = 1 alongside done; load_data is unchanged. Counter clears on entry to READ/WRITE.
- req_valid changes while busy: ignored.

Decomposition:
- Shared package mips_cpu_pkg:
  - opcode localparams (OP_LB … OP_SW);
  - lsu_state_t enum {IDLE, READ, WRITE, DONE};
  - functions is_load and is_store.
- One combinational sub-module mips_cpu_lsu_store_align: inputs opcode, addr[1:0], wdata; outputs byteenable, writedata. It is shared by the store path.

Test Plan:
- lw addr 0x1004, waitrequest = 0, readdata 0xDEADBEEF -> avm_address 0x1004, byteenable 1111, done 2 cycles after request edge, load_data 0xDEADBEEF, addr_offset 0.
- sb addr 0x2003, wdata 0x000000A5, waitrequest high 3 cycles -> byteenable 1000, writedata 0xA5A5A5A5, strobe held 4 cycles with stable address 0x2000, then done.
- sh addr 0x3001 -> misaligned pulse, no avm_read/avm_write, busy stays 0; lh addr 0x3002 -> byteenable 1111 read, addr_offset 2.
- lwr addr 0x4003, waitrequest stuck high, TIMEOUT_CYCLES = 4 -> strobe drops after 4 wait cycles, done and bus_error pulse together, load_data unchanged.
- reset_n low during READ wait -> avm_read 0 immediately, busy 0, no done; next lbu after reset completes normally.
- opcode 000000 with req_valid = 1 -> no strobe, no pulses; back-to-back sw requests held valid -> second accepted only after DONE returns to IDLE.
